tvip_axi_burst_addr_gen: RTL and testbench
==========================================

TVIP_AXI_BURST_ADDR_GEN -- requirements
Module: tvip_axi_burst_addr_gen

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4, meaning the command/beat ID width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, meaning the address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, meaning the bus width in bits; BUS_BYTES = DATA_WIDTH/8, a power of 2 in 1..128.
REQ-004 SHALL have ports: aclk  in  1  clock; areset_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: cmd_valid  in  1; cmd_ready  out  1; cmd_id  in  ID_WIDTH; cmd_addr  in  ADDRESS_WIDTH; cmd_len  in  8  (encoded beats-1); cmd_size  in  3  (log2 bytes); cmd_burst  in  2  (00 FIXED, 01 INCR, 10 WRAP).
REQ-006 SHALL have ports: beat_valid  out  1; beat_ready  in  1; beat_id  out  ID_WIDTH; beat_addr  out  ADDRESS_WIDTH; beat_index  out  8; beat_strobe  out  BUS_BYTES  (active byte lanes); beat_last  out  1; beat_error  out  1.

Function
REQ-007 SHALL implement FSM states IDLE and BURST; cmd_ready = 1 only in IDLE.
REQ-008 SHALL transition IDLE->BURST on cmd_valid && cmd_ready, capturing all cmd fields; first beat_valid is asserted on the next cycle (latency 1).
REQ-009 SHALL transition BURST->IDLE on beat_valid && beat_ready && beat_last; no command is accepted in that cycle (one-cycle bubble).
REQ-010 SHALL hold every beat_* output stable while beat_valid && !beat_ready.
REQ-011 SHALL set beat_index 0 for the first beat and increment it by 1 per accepted beat; beat_last = (beat_index == captured cmd_len).
REQ-012 SHALL output cmd_addr as beat_addr for beat 0 under every burst type.
REQ-013 FIXED: SHALL output cmd_addr for every beat.
REQ-014 INCR: SHALL output beat i>0 as align(cmd_addr, 2^size) + i*2^size, with modulo-2^ADDRESS_WIDTH arithmetic.
REQ-015 WRAP: SHALL compute total = 2^size*(len+1) and boundary = cmd_addr rounded down to a multiple of total; SHALL form each next address as previous aligned address + 2^size, replaced by boundary when the result equals boundary + total.
REQ-016 SHALL set beat_strobe bits from (beat_addr mod BUS_BYTES) up to (align(beat_addr, 2^size) mod BUS_BYTES) + 2^size - 1, clipped to BUS_BYTES-1; all other bits 0.
REQ-017 SHALL treat cmd_size above log2(BUS_BYTES) per REQ-022, or as log2(BUS_BYTES) when the check is disabled.

Reset
REQ-018 SHALL, while areset_n = 0, force state IDLE, cmd_ready 0, beat_valid 0, and beat_addr, beat_id, beat_index, beat_strobe, beat_last, and beat_error to 0.
REQ-019 SHALL drive cmd_ready 1 from the first aclk rising edge after areset_n deasserts.
REQ-020 SHALL, on reset asserted mid-burst, abandon the burst without emitting further beats after release.

Configuration
REQ-021 SHALL gate the burst legality check with macro TVIP_AXI_BURST_ERROR_CHECK_EN.
REQ-022 With TVIP_AXI_BURST_ERROR_CHECK_EN defined, SHALL set beat_error = 1 on all beats of a burst that has any of the following:
- cmd_burst = 11;
- WRAP with len+1 not in {2,4,8,16};
- cmd_size > log2(BUS_BYTES);
- INCR crossing a 4KB boundary.
REQ-023 With TVIP_AXI_BURST_ERROR_CHECK_EN defined, SHALL still generate all len+1 beats of an errored burst, with addresses computed as INCR when cmd_burst = 11.
REQ-024 Without TVIP_AXI_BURST_ERROR_CHECK_EN, SHALL tie beat_error to 0 and treat cmd_burst = 11 as INCR.

Verification
REQ-025 WRAP: addr 0x1034, size 2, len 3 -> beat_addr 0x1034, 0x1038, 0x103C, 0x1030; strobe 1111 on every beat; beat_last only on beat 3.
REQ-026 INCR unaligned: addr 0x1001, size 2, len 2 -> beat_addr 0x1001/1110, 0x1004/1111, 0x1008/1111.
REQ-027 FIXED: addr 0x2002, size 1, len 1 -> beat_addr 0x2002 twice, strobe 1100 both beats, beat_index 0 then 1.
REQ-028 Backpressure: beat_ready low for 3 cycles on beat 1 -> all beat_* outputs unchanged across those cycles; cmd_ready 0 throughout the burst.
REQ-029 Error (macro defined): addr 0x0FFC, size 2, len 1, INCR -> beat_error 1 on both beats; without the macro -> beat_error 0 and beats 0x0FFC, 0x1000.
REQ-030 areset_n pulsed low during beat 2 of a len 7 burst -> beat_valid 0 immediately; cmd_ready 1 at the first edge after release; no stale beats.

Source files
------------

// File: rtl/tvip_axi_burst_addr_gen.sv
// AXI burst address generator: expands one FIXED/INCR/WRAP command into per-beat address, lane strobe and last.
// Optional burst legality check enabled by defining TVIP_AXI_BURST_ERROR_CHECK_EN.
module tvip_axi_burst_addr_gen #(
  parameter  int ID_WIDTH      = 4,
  parameter  int ADDRESS_WIDTH = 32,
  parameter  int DATA_WIDTH    = 32,
  localparam int BUS_BYTES     = DATA_WIDTH / 8
) (
  input  logic                     aclk,
  input  logic                     areset_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [ID_WIDTH-1:0]      cmd_id,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [7:0]               cmd_len,
  input  logic [2:0]               cmd_size,
  input  logic [1:0]               cmd_burst,
  output logic                     beat_valid,
  input  logic                     beat_ready,
  output logic [ID_WIDTH-1:0]      beat_id,
  output logic [ADDRESS_WIDTH-1:0] beat_addr,
  output logic [7:0]               beat_index,
  output logic [BUS_BYTES-1:0]     beat_strobe,
  output logic                     beat_last,
  output logic                     beat_error
);

  localparam int AW        = ADDRESS_WIDTH;
  localparam int BUS_SHIFT = $clog2(BUS_BYTES);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_e;

  state_e                state_q, state_d;
  burst_e                burst_q, burst_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  beat_valid_q, beat_valid_d;
  logic [ID_WIDTH-1:0]   beat_id_q, beat_id_d;
  logic [AW-1:0]         beat_addr_q, beat_addr_d;
  logic [7:0]            beat_index_q, beat_index_d;
  logic [BUS_BYTES-1:0]  beat_strobe_q, beat_strobe_d;
  logic                  beat_last_q, beat_last_d;
  logic                  beat_error_q, beat_error_d;
  logic [7:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [AW-1:0]         wrap_lo_q, wrap_lo_d;
  logic [AW-1:0]         wrap_hi_q, wrap_hi_d;

  logic [2:0]            cmd_eff_size;
  logic [AW-1:0]         cmd_bytes;
  logic [AW-1:0]         cmd_total;
  logic [AW-1:0]         cmd_boundary;
  burst_e                cmd_burst_eff;
  logic                  cmd_err;
  logic [AW-1:0]         cur_bytes;
  logic [AW-1:0]         next_addr;

  // Lanes from the byte address up to the end of its size-aligned container, clipped to the bus.
  function automatic logic [BUS_BYTES-1:0] lane_strobe(input logic [AW-1:0] addr,
                                                        input logic [2:0]    size);
    logic [AW-1:0] lane_mask;
    logic [AW-1:0] size_mask;
    int unsigned   lo;
    int unsigned   hi;
    lane_mask = AW'(BUS_BYTES - 1);
    size_mask = (AW'(1) << size) - AW'(1);
    lo = 32'(addr & lane_mask);
    hi = 32'((addr & ~size_mask) & lane_mask) + (32'd1 << size) - 32'd1;
    if (hi > BUS_BYTES - 1) hi = BUS_BYTES - 1;
    lane_strobe = '0;
    for (int unsigned i = 0; i < BUS_BYTES; i++) begin
      lane_strobe[i] = (i >= lo) && (i <= hi);
    end
  endfunction

  always_comb begin
    cmd_eff_size = (cmd_size > 3'(BUS_SHIFT)) ? 3'(BUS_SHIFT) : cmd_size;
    cmd_bytes    = AW'(1) << cmd_eff_size;
    cmd_total    = cmd_bytes * (AW'(cmd_len) + AW'(1));
    cmd_boundary = (cmd_total == '0) ? '0 : cmd_addr - (cmd_addr % cmd_total);
    case (cmd_burst)
      2'b00:   cmd_burst_eff = BURST_FIXED;
      2'b10:   cmd_burst_eff = BURST_WRAP;
      default: cmd_burst_eff = BURST_INCR;
    endcase
  end

`ifdef TVIP_AXI_BURST_ERROR_CHECK_EN
  logic [AW-1:0] cmd_aligned;
  logic [31:0]   page_end;

  always_comb begin
    cmd_aligned = cmd_addr & ~(cmd_bytes - AW'(1));
    page_end    = 32'(cmd_aligned & AW'(12'hFFF)) + 32'(cmd_len) * (32'd1 << cmd_eff_size);
    cmd_err     = 1'b0;
    if (cmd_burst == 2'b11) cmd_err = 1'b1;
    if ((cmd_burst == 2'b10) &&
        !((cmd_len == 8'd1) || (cmd_len == 8'd3) || (cmd_len == 8'd7) || (cmd_len == 8'd15)))
      cmd_err = 1'b1;
    if (cmd_size > 3'(BUS_SHIFT)) cmd_err = 1'b1;
    if ((cmd_burst_eff == BURST_INCR) && (page_end > 32'hFFF)) cmd_err = 1'b1;
  end
`else
  always_comb begin
    cmd_err = 1'b0;
  end
`endif

  // Beat 0 may be unaligned; every later INCR/WRAP beat steps from the aligned form of the current one.
  always_comb begin
    cur_bytes = AW'(1) << size_q;
    next_addr = (beat_addr_q & ~(cur_bytes - AW'(1))) + cur_bytes;
    case (burst_q)
      BURST_FIXED: next_addr = beat_addr_q;
      BURST_WRAP:  if (next_addr == wrap_hi_q) next_addr = wrap_lo_q;
      default:     ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    burst_d       = burst_q;
    cmd_ready_d   = cmd_ready_q;
    beat_valid_d  = beat_valid_q;
    beat_id_d     = beat_id_q;
    beat_addr_d   = beat_addr_q;
    beat_index_d  = beat_index_q;
    beat_strobe_d = beat_strobe_q;
    beat_last_d   = beat_last_q;
    beat_error_d  = beat_error_q;
    len_d         = len_q;
    size_d        = size_q;
    wrap_lo_d     = wrap_lo_q;
    wrap_hi_d     = wrap_hi_q;
    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          state_d       = BURST;
          cmd_ready_d   = 1'b0;
          beat_valid_d  = 1'b1;
          beat_id_d     = cmd_id;
          beat_addr_d   = cmd_addr;
          beat_index_d  = '0;
          beat_strobe_d = lane_strobe(cmd_addr, cmd_eff_size);
          beat_last_d   = (cmd_len == 8'd0);
          beat_error_d  = cmd_err;
          len_d         = cmd_len;
          size_d        = cmd_eff_size;
          burst_d       = cmd_burst_eff;
          wrap_lo_d     = cmd_boundary;
          wrap_hi_d     = cmd_boundary + cmd_total;
        end
      end
      BURST: begin
        cmd_ready_d = 1'b0;
        if (beat_valid_q && beat_ready) begin
          if (beat_last_q) begin
            state_d      = IDLE;
            beat_valid_d = 1'b0;
            cmd_ready_d  = 1'b1;
          end else begin
            beat_addr_d   = next_addr;
            beat_index_d  = beat_index_q + 8'd1;
            beat_strobe_d = lane_strobe(next_addr, size_q);
            beat_last_d   = ((beat_index_q + 8'd1) == len_q);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state_q       <= IDLE;
      burst_q       <= BURST_FIXED;
      cmd_ready_q   <= 1'b0;
      beat_valid_q  <= 1'b0;
      beat_id_q     <= '0;
      beat_addr_q   <= '0;
      beat_index_q  <= '0;
      beat_strobe_q <= '0;
      beat_last_q   <= 1'b0;
      beat_error_q  <= 1'b0;
      len_q         <= '0;
      size_q        <= '0;
      wrap_lo_q     <= '0;
      wrap_hi_q     <= '0;
    end else begin
      state_q       <= state_d;
      burst_q       <= burst_d;
      cmd_ready_q   <= cmd_ready_d;
      beat_valid_q  <= beat_valid_d;
      beat_id_q     <= beat_id_d;
      beat_addr_q   <= beat_addr_d;
      beat_index_q  <= beat_index_d;
      beat_strobe_q <= beat_strobe_d;
      beat_last_q   <= beat_last_d;
      beat_error_q  <= beat_error_d;
      len_q         <= len_d;
      size_q        <= size_d;
      wrap_lo_q     <= wrap_lo_d;
      wrap_hi_q     <= wrap_hi_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign beat_valid  = beat_valid_q;
  assign beat_id     = beat_id_q;
  assign beat_addr   = beat_addr_q;
  assign beat_index  = beat_index_q;
  assign beat_strobe = beat_strobe_q;
  assign beat_last   = beat_last_q;
  assign beat_error  = beat_error_q;

endmodule

// File: tb/tb_tvip_axi_burst_addr_gen.sv
// Scoreboard bench for tvip_axi_burst_addr_gen: directed vectors, randomized bursts, backpressure and mid-burst reset.
module tb_tvip_axi_burst_addr_gen;

  localparam int IDW = 4;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int BB  = DW / 8;
  localparam int BSH = $clog2(BB);

  logic           aclk = 1'b0;
  logic           areset_n;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [IDW-1:0] cmd_id;
  logic [AW-1:0]  cmd_addr;
  logic [7:0]     cmd_len;
  logic [2:0]     cmd_size;
  logic [1:0]     cmd_burst;
  logic           beat_valid;
  logic           beat_ready;
  logic [IDW-1:0] beat_id;
  logic [AW-1:0]  beat_addr;
  logic [7:0]     beat_index;
  logic [BB-1:0]  beat_strobe;
  logic           beat_last;
  logic           beat_error;

  typedef struct {
    logic [IDW-1:0] id;
    logic [AW-1:0]  addr;
    logic [7:0]     idx;
    logic [BB-1:0]  strb;
    logic           last;
    logic           err;
  } beat_t;

  beat_t exp_q[$];
  beat_t e;
  int    n_tests = 0;
  int    n_fail = 0;
  int    ready_mode = 0;
`ifdef TVIP_AXI_BURST_ERROR_CHECK_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  always #5 aclk = ~aclk;

  tvip_axi_burst_addr_gen #(
    .ID_WIDTH     (IDW),
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW)
  ) dut (
    .aclk       (aclk),
    .areset_n   (areset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_id     (cmd_id),
    .cmd_addr   (cmd_addr),
    .cmd_len    (cmd_len),
    .cmd_size   (cmd_size),
    .cmd_burst  (cmd_burst),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_id    (beat_id),
    .beat_addr  (beat_addr),
    .beat_index (beat_index),
    .beat_strobe(beat_strobe),
    .beat_last  (beat_last),
    .beat_error (beat_error)
  );

  function automatic void push_beat(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                                    input logic [7:0] idx, input logic [BB-1:0] strb,
                                    input logic last, input logic err);
    beat_t b;
    b.id = id; b.addr = addr; b.idx = idx; b.strb = strb; b.last = last; b.err = err;
    exp_q.push_back(b);
  endfunction

  // Reference: closed-form addresses per beat number, independent of any step-by-step recurrence.
  function automatic void model_push(input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                                     input logic [7:0] len, input logic [2:0] size,
                                     input logic [1:0] burst);
    int unsigned eff, bytes, b, nb, lo, hi;
    logic [AW-1:0] al, total, bnd, a;
    logic [BB-1:0] s;
    logic          err;
    eff   = (int'(size) > BSH) ? BSH : int'(size);
    bytes = 1 << eff;
    b     = (burst == 2'b11) ? 1 : int'(burst);
    nb    = int'(len) + 1;
    al    = addr - (addr % bytes);
    total = bytes * nb;
    bnd   = addr - (addr % total);
    err   = 1'b0;
    if (ERR_EN) begin
      err = (burst == 2'b11) || (burst == 2'b10 && !(nb inside {2, 4, 8, 16})) ||
            (int'(size) > BSH) || (b == 1 && (al % 4096) + int'(len) * bytes > 4095);
    end
    for (int unsigned i = 0; i < nb; i++) begin
      if (i == 0 || b == 0) a = addr;
      else if (b == 1) a = al + i * bytes;
      else a = bnd + ((al - bnd) + i * bytes) % total;
      lo = a % BB;
      hi = (a - (a % bytes)) % BB + bytes - 1;
      if (hi > BB - 1) hi = BB - 1;
      for (int unsigned j = 0; j < BB; j++) s[j] = (j >= lo) && (j <= hi);
      push_beat(id, a, 8'(i), s, (i == int'(len)), err);
    end
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send_cmd(input logic [IDW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input bit use_model);
    bit ok = 0;
    if (use_model) model_push(id, addr, len, size, burst);
    cmd_valid = 1'b1; cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
    for (int k = 0; k < 2000; k++) begin
      @(negedge aclk);
      if (cmd_ready === 1'b1) begin ok = 1; break; end
    end
    @(posedge aclk);
    #1 cmd_valid = 1'b0;
    check("cmd_accepted", 64'(ok), 64'd1);
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 4000; k++) begin
      if (exp_q.size() == 0) break;
      @(posedge aclk);
    end
    #1 check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    beat_ready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      if (ready_mode == 0) beat_ready = 1'b1;
      else if (ready_mode == 1) beat_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge aclk) begin
    if (areset_n === 1'b1 && beat_valid === 1'b1) begin
      check("cmd_ready_in_burst", 64'(cmd_ready), 64'd0);
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_beat: got addr=%h idx=%0d want no beat", beat_addr, beat_index);
      end else begin
        e = exp_q[0];
        n_tests++;
        if (beat_id !== e.id || beat_addr !== e.addr || beat_index !== e.idx ||
            beat_strobe !== e.strb || beat_last !== e.last || beat_error !== e.err) begin
          n_fail++;
          $display("FAIL beat: got id=%h addr=%h idx=%0d strb=%b last=%b err=%b want id=%h addr=%h idx=%0d strb=%b last=%b err=%b",
                   beat_id, beat_addr, beat_index, beat_strobe, beat_last, beat_error,
                   e.id, e.addr, e.idx, e.strb, e.last, e.err);
        end
        if (beat_ready === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    logic [1:0] rb;
    logic [2:0] rs;
    logic [7:0] rl;
    areset_n = 1'b0; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0;
    repeat (3) @(negedge aclk);
    check("reset_outputs", 64'({cmd_ready, beat_valid, beat_addr, beat_id, beat_index, beat_strobe, beat_last, beat_error}), 64'd0);
    @(posedge aclk);
    #2 areset_n = 1'b1;
    #1 check("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
    @(posedge aclk);
    #1 check("cmd_ready_after_release", 64'(cmd_ready), 64'd1);

    push_beat(4'd1, 32'h1034, 8'd0, 4'b1111, 1'b0, 1'b0);
    push_beat(4'd1, 32'h1038, 8'd1, 4'b1111, 1'b0, 1'b0);
    push_beat(4'd1, 32'h103C, 8'd2, 4'b1111, 1'b0, 1'b0);
    push_beat(4'd1, 32'h1030, 8'd3, 4'b1111, 1'b1, 1'b0);
    send_cmd(4'd1, 32'h1034, 8'd3, 3'd2, 2'b10, 0);
    wait_drain();
    push_beat(4'd2, 32'h1001, 8'd0, 4'b1110, 1'b0, 1'b0);
    push_beat(4'd2, 32'h1004, 8'd1, 4'b1111, 1'b0, 1'b0);
    push_beat(4'd2, 32'h1008, 8'd2, 4'b1111, 1'b1, 1'b0);
    send_cmd(4'd2, 32'h1001, 8'd2, 3'd2, 2'b01, 0);
    wait_drain();
    push_beat(4'd3, 32'h2002, 8'd0, 4'b1100, 1'b0, 1'b0);
    push_beat(4'd3, 32'h2002, 8'd1, 4'b1100, 1'b1, 1'b0);
    send_cmd(4'd3, 32'h2002, 8'd1, 3'd1, 2'b00, 0);
    wait_drain();
    push_beat(4'd4, 32'h0FFC, 8'd0, 4'b1111, 1'b0, ERR_EN);
    push_beat(4'd4, 32'h1000, 8'd1, 4'b1111, 1'b1, ERR_EN);
    send_cmd(4'd4, 32'h0FFC, 8'd1, 3'd2, 2'b01, 0);
    wait_drain();
    send_cmd(4'd5, 32'h0000_5006, 8'd0, 3'd2, 2'b01, 1);
    send_cmd(4'd6, 32'hFFFF_FFF8, 8'd3, 3'd2, 2'b01, 1);
    send_cmd(4'd7, 32'h0000_7003, 8'd2, 3'd6, 2'b11, 1);
    wait_drain();

    ready_mode = 2;
    beat_ready = 1'b1;
    send_cmd(4'd8, 32'h4000, 8'd3, 3'd2, 2'b01, 1);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (beat_valid === 1'b1 && beat_index === 8'd1) begin found = 1; break; end
      @(posedge aclk);
      #1;
    end
    check("stall_beat1_seen", 64'(found), 64'd1);
    beat_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      check("stall_valid_held", 64'(beat_valid), 64'd1);
      @(posedge aclk);
      #1;
    end
    beat_ready = 1'b1;
    ready_mode = 0;
    wait_drain();

    ready_mode = 1;
    for (int n = 0; n < 40; n++) begin
      rb = 2'($urandom_range(0, 3));
      rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, BSH));
      if (rb == 2'b10 && $urandom_range(0, 7) != 0) rl = 8'((1 << $urandom_range(1, 4)) - 1);
      else rl = 8'($urandom_range(0, 15));
      send_cmd(4'($urandom), 32'($urandom), rl, rs, rb, 1);
    end
    wait_drain();

    ready_mode = 0;
    send_cmd(4'd9, 32'h3000, 8'd7, 3'd2, 2'b01, 1);
    found = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge aclk);
      if (beat_valid === 1'b1 && beat_index === 8'd2) begin found = 1; break; end
    end
    check("reset_beat2_seen", 64'(found), 64'd1);
    #2 areset_n = 1'b0;
    #1 check("reset_mid_burst_outputs", 64'({beat_valid, beat_addr, beat_index, beat_strobe, beat_last}), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge aclk);
    #2 areset_n = 1'b1;
    #1 check("cmd_ready_before_edge2", 64'(cmd_ready), 64'd0);
    @(posedge aclk);
    #1 check("cmd_ready_after_release2", 64'(cmd_ready), 64'd1);
    found = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge aclk);
      if (beat_valid !== 1'b0) found = 1;
    end
    check("no_stale_beats", 64'(found), 64'd0);
    send_cmd(4'd10, 32'h0000_6001, 8'd2, 3'd0, 2'b00, 1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
